// File: rtl/sv39_ptw_pkg.sv
// Shared Sv39 walker constants: PTE fields, fault causes, access-type bits, FSM states.
package sv39_ptw_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PPN_LSB = 10;
    localparam int PPN_MSB = 53;
    localparam int RSV_LSB = 54;
    localparam int RSV_MSB = 63;

    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

    localparam logic [5:0] ECAUSE_INST_PF  = 6'd12;
    localparam logic [5:0] ECAUSE_LOAD_PF  = 6'd13;
    localparam logic [5:0] ECAUSE_STORE_PF = 6'd15;

    localparam int ACC_LOAD  = 0;
    localparam int ACC_STORE = 1;
    localparam int ACC_EXEC  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_DONE,
        ST_DRAIN
    } ptw_state_e;

    // Page-fault cause for a one-hot access type; load is the fallback.
    function automatic logic [5:0] ecause_for(input logic [2:0] acc);
        if (acc[ACC_EXEC])       return ECAUSE_INST_PF;
        else if (acc[ACC_STORE]) return ECAUSE_STORE_PF;
        else                     return ECAUSE_LOAD_PF;
    endfunction

endpackage

// File: rtl/sv39_pte_check.sv
// Combinational decode of one fetched PTE: leaf/pointer and whether it faults.
module sv39_pte_check
    import sv39_ptw_pkg::*;
(
    input  logic [63:0] pte,
    input  logic [1:0]  level,
    input  logic [2:0]  access_type,
    output logic        is_leaf,
    output logic        fault
);

    logic misaligned;
    logic perm_ok;

    // Superpage leaves must have the PPN bits below their level cleared; no hardware A/D update.
    always_comb begin
        is_leaf    = pte[PTE_R] | pte[PTE_X];
        misaligned = ((level == 2'd1) && (pte[PPN_LSB+8:PPN_LSB]  != '0)) ||
                     ((level == 2'd2) && (pte[PPN_LSB+17:PPN_LSB] != '0));
        perm_ok    = (!access_type[ACC_LOAD]  | pte[PTE_R]) &
                     (!access_type[ACC_STORE] | pte[PTE_W]) &
                     (!access_type[ACC_EXEC]  | pte[PTE_X]);
        fault      = !pte[PTE_V] | (!pte[PTE_R] & pte[PTE_W]) |
                     (pte[RSV_MSB:RSV_LSB] != '0);
        if (is_leaf) begin
            fault = fault | misaligned | !perm_ok | !pte[PTE_A] |
                    (access_type[ACC_STORE] & !pte[PTE_D]);
        end else begin
            fault = fault | (level == 2'd0);
        end
    end

endmodule

// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: one outstanding DTLB miss, up to three PTE reads, leaf or fault result.
//   state | meaning
//   IDLE  | ready for a miss
//   REQ   | start-burst pulse for the current level's PTE
//   WAIT  | waiting for the PTE ack
//   CHECK | decode fetched PTE: descend, finish or fault
//   DONE  | result pulse to the DTLB
//   DRAIN | walk flushed, swallowing the outstanding ack
module sv39_ptw
    import sv39_ptw_pkg::*;
#(
    parameter int ECAUSE_W = 6,
    parameter int PA_W     = 56
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_vaddr,
    input  logic [2:0]          req_access_type,
    input  logic [63:0]         csr_satp,
    input  logic                flush,
    output logic                mem_req_valid,
    output logic [63:0]         mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [63:0]         mem_resp_data,
    output logic                resp_valid,
    output logic [63:0]         resp_pte,
    output logic [1:0]          resp_level,
    output logic                resp_exception,
    output logic [ECAUSE_W-1:0] resp_ecause,
    output logic                busy
);

    ptw_state_e          state_q;
    logic [38:12]        va_q;
    logic [2:0]          acc_q;
    logic [PA_W-1:0]     base_q;
    logic [1:0]          level_q;
    logic [63:0]         pte_q;
    logic                flush_seen_q;
    logic                mem_req_valid_q;
    logic                resp_valid_q;
    logic [63:0]         resp_pte_q;
    logic [1:0]          resp_level_q;
    logic                resp_exc_q;
    logic [ECAUSE_W-1:0] resp_ecause_q;

    logic [8:0]          vpn;
    logic                chk_leaf;
    logic                chk_fault;
    logic                non_canonical;
    logic                unused;

    sv39_pte_check u_check (
        .pte         (pte_q),
        .level       (level_q),
        .access_type (acc_q),
        .is_leaf     (chk_leaf),
        .fault       (chk_fault)
    );

    // VPN slice for the level being fetched.
    always_comb begin
        vpn = va_q[20:12];
        if (level_q == 2'd2)      vpn = va_q[38:30];
        else if (level_q == 2'd1) vpn = va_q[29:21];
    end

    assign non_canonical = (req_vaddr[63:39] != {25{req_vaddr[38]}});
    assign mem_req_addr  = {{(64-PA_W){1'b0}}, base_q + {{(PA_W-12){1'b0}}, vpn, 3'b000}};
    assign mem_req_valid = mem_req_valid_q;
    assign req_ready     = rst && (state_q == ST_IDLE) && !flush;
    assign busy          = (state_q != ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_pte      = resp_pte_q;
    assign resp_level    = resp_level_q;
    assign resp_exception = resp_exc_q;
    assign resp_ecause   = resp_ecause_q;
    assign unused        = ^{csr_satp[63:44], req_vaddr[11:0], csr_satp[63:60] == SATP_MODE_SV39};

    // Walk FSM with registered pulse and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            va_q            <= '0;
            acc_q           <= '0;
            base_q          <= '0;
            level_q         <= '0;
            pte_q           <= '0;
            flush_seen_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_pte_q      <= '0;
            resp_level_q    <= '0;
            resp_exc_q      <= 1'b0;
            resp_ecause_q   <= '0;
        end else begin
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_pte_q      <= '0;
            resp_level_q    <= '0;
            resp_exc_q      <= 1'b0;
            resp_ecause_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    flush_seen_q <= 1'b0;
                    if (req_valid && !flush) begin
                        va_q    <= req_vaddr[38:12];
                        acc_q   <= req_access_type;
                        base_q  <= {csr_satp[43:0], 12'h000};
                        level_q <= 2'd2;
                        if (non_canonical) begin
                            state_q       <= ST_DONE;
                            resp_valid_q  <= 1'b1;
                            resp_exc_q    <= 1'b1;
                            resp_ecause_q <= ECAUSE_W'(ecause_for(req_access_type));
                        end else begin
                            state_q         <= ST_REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) flush_seen_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        if (flush || flush_seen_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            pte_q   <= mem_resp_data;
                            state_q <= ST_CHECK;
                        end
                    end else if (flush || flush_seen_q) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_CHECK: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (chk_fault) begin
                        state_q       <= ST_DONE;
                        resp_valid_q  <= 1'b1;
                        resp_exc_q    <= 1'b1;
                        resp_level_q  <= level_q;
                        resp_ecause_q <= ECAUSE_W'(ecause_for(acc_q));
                    end else if (chk_leaf) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        resp_pte_q   <= pte_q;
                        resp_level_q <= level_q;
                    end else begin
                        base_q          <= {pte_q[PPN_MSB:PPN_LSB], 12'h000};
                        level_q         <= level_q - 2'd1;
                        state_q         <= ST_REQ;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                ST_DRAIN: if (mem_resp_valid) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sv39_ptw.sv
// Directed bench for sv39_ptw: walk vector table plus flush and reset sequences.
module tb_sv39_ptw;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_vaddr;
    logic [2:0]  req_access_type;
    logic [63:0] csr_satp;
    logic        flush;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        resp_valid;
    logic [63:0] resp_pte;
    logic [1:0]  resp_level;
    logic        resp_exception;
    logic [5:0]  resp_ecause;
    logic        busy;

    sv39_ptw #(.ECAUSE_W(6), .PA_W(56)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vaddr       (req_vaddr),
        .req_access_type (req_access_type),
        .csr_satp        (csr_satp),
        .flush           (flush),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .resp_valid      (resp_valid),
        .resp_pte        (resp_pte),
        .resp_level      (resp_level),
        .resp_exception  (resp_exception),
        .resp_ecause     (resp_ecause),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [63:0]     vaddr;
        logic [2:0]      acc;
        int              nreads;
        logic [63:0]     ptes  [3];
        logic [63:0]     addrs [3];
        logic            exc;
        logic [5:0]      cause;
        logic [1:0]      level;
        logic [63:0]     pte;
        int              lat;
    } vec_t;

    localparam logic [63:0] SATP = 64'h8000_0000_0008_0000;
    localparam logic [63:0] P_L2 = 64'h2000_0401;
    localparam logic [63:0] P_L1 = 64'h2000_0801;
    localparam logic [63:0] A_L2 = 64'h8000_0008;
    localparam logic [63:0] A_L1 = 64'h8000_1008;
    localparam logic [63:0] A_L0 = 64'h8000_2008;

    int total = 0;
    int passed = 0;
    int mon_resp = 0;
    int mon_req = 0;
    vec_t vecs [8];

    always @(negedge clk) begin
        if (resp_valid)    mon_resp++;
        if (mem_req_valid) mon_req++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [63:0] va, input logic [2:0] acc,
                                input int n, input logic [63:0] p0, p1, p2,
                                input logic exc, input logic [5:0] cause, input logic [1:0] lvl,
                                input logic [63:0] pte, input int lat);
        vec_t v;
        v.name = name; v.vaddr = va; v.acc = acc; v.nreads = n;
        v.ptes[0] = p0; v.ptes[1] = p1; v.ptes[2] = p2;
        v.addrs[0] = A_L2; v.addrs[1] = A_L1; v.addrs[2] = A_L0;
        v.exc = exc; v.cause = cause; v.level = lvl; v.pte = pte; v.lat = lat;
        return v;
    endfunction

    task automatic issue(input logic [63:0] va, input logic [2:0] acc);
        @(negedge clk);
        chk("req_ready_at_issue", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; req_vaddr = va; req_access_type = acc; csr_satp = SATP;
    endtask

    // Accept a miss, answer each start-burst with a 1-cycle ack, then check the result.
    task automatic run_walk(input vec_t v);
        int  reads = 0;
        int  t_resp = 999;
        bit  ack_pend = 0;
        logic [63:0] r_pte = '0;
        logic [1:0]  r_lvl = '0;
        logic        r_exc = 1'b0;
        logic [5:0]  r_cause = '0;
        issue(v.vaddr, v.acc);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_resp_valid = 1'b0;
            if (ack_pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = v.ptes[reads-1];
                ack_pend = 0;
            end
            if (mem_req_valid) begin
                if (reads < 3) chk({v.name, "_addr"}, mem_req_addr, v.addrs[reads]);
                reads++;
                ack_pend = 1;
            end
            if (resp_valid) begin
                t_resp = t; r_pte = resp_pte; r_lvl = resp_level;
                r_exc = resp_exception; r_cause = resp_ecause;
                break;
            end
        end
        mem_resp_valid = 1'b0;
        chk({v.name, "_latency"}, 64'(t_resp), 64'(v.lat));
        chk({v.name, "_reads"}, 64'(reads), 64'(v.nreads));
        chk({v.name, "_exception"}, {63'b0, r_exc}, {63'b0, v.exc});
        chk({v.name, "_ecause"}, {58'b0, r_cause}, {58'b0, v.cause});
        chk({v.name, "_pte"}, r_pte, v.pte);
        if (!v.exc) chk({v.name, "_level"}, {62'b0, r_lvl}, {62'b0, v.level});
        @(negedge clk);
        chk({v.name, "_idle_after"}, {62'b0, busy, req_ready}, 64'b01);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_access_type = '0;
        csr_satp = '0; flush = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        vecs[0] = mk("walk4k_load", 64'h4020_1ABC, 3'b001, 3, P_L2, P_L1, 64'h048D_14CF,
                     1'b0, 6'd0, 2'd0, 64'h048D_14CF, 10);
        vecs[1] = mk("giga_leaf", 64'h4020_1ABC, 3'b001, 1, 64'h1000_00CF, 0, 0,
                     1'b0, 6'd0, 2'd2, 64'h1000_00CF, 4);
        vecs[2] = mk("giga_misaligned", 64'h4020_1ABC, 3'b001, 1, 64'h1000_04CF, 0, 0,
                     1'b1, 6'd13, 2'd2, 64'h0, 4);
        vecs[3] = mk("invalid_l1_store", 64'h4020_1ABC, 3'b010, 2, P_L2, 64'h0, 0,
                     1'b1, 6'd15, 2'd1, 64'h0, 7);
        vecs[4] = mk("store_dirty0", 64'h4020_1ABC, 3'b010, 3, P_L2, P_L1, 64'h048D_144F,
                     1'b1, 6'd15, 2'd0, 64'h0, 10);
        vecs[5] = mk("load_dirty0", 64'h4020_1ABC, 3'b001, 3, P_L2, P_L1, 64'h048D_144F,
                     1'b0, 6'd0, 2'd0, 64'h048D_144F, 10);
        vecs[6] = mk("non_canonical", 64'h0000_0040_0000_0000, 3'b001, 0, 0, 0, 0,
                     1'b1, 6'd13, 2'd0, 64'h0, 1);
        vecs[7] = mk("exec_no_x", 64'h4020_1ABC, 3'b100, 3, P_L2, P_L1, 64'h048D_14C7,
                     1'b1, 6'd12, 2'd0, 64'h0, 10);

        repeat (2) @(negedge clk);
        chk("rst_outputs", {busy, mem_req_valid, resp_valid, resp_exception},  4'b0);
        chk("rst_addr", mem_req_addr, 64'h0);
        chk("rst_pte", resp_pte, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'b0, req_ready}, 64'd1);

        for (int i = 0; i < 8; i++) run_walk(vecs[i]);

        // Flush while waiting for the first ack; the late ack must be swallowed.
        mon_resp = 0; mon_req = 0;
        issue(64'h4020_1ABC, 3'b001);
        @(negedge clk); req_valid = 1'b0;
        chk("flush_req_pulse", {63'b0, mem_req_valid}, 64'd1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_drain_busy", {62'b0, busy, req_ready}, 64'b10);
        @(negedge clk);
        chk("flush_drain_hold", {62'b0, busy, req_ready}, 64'b10);
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = P_L2;
        chk("flush_before_ack", {63'b0, req_ready}, 64'd0);
        @(negedge clk); mem_resp_valid = 1'b0;
        chk("flush_ready_after_ack", {62'b0, busy, req_ready}, 64'b01);
        repeat (5) @(negedge clk);
        chk("flush_no_resp", 64'(mon_resp), 64'd0);
        chk("flush_one_req", 64'(mon_req), 64'd1);

        // Reset mid-walk; the ack arriving afterwards must not revive the walk.
        mon_resp = 0; mon_req = 0;
        issue(64'h4020_1ABC, 3'b001);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        chk("midrst_outputs", {busy, mem_req_valid, resp_valid, resp_exception}, 4'b0);
        chk("midrst_addr", mem_req_addr, 64'h0);
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = P_L2;
        chk("midrst_ready", {62'b0, busy, req_ready}, 64'b01);
        @(negedge clk); mem_resp_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_idle", {62'b0, busy, req_ready}, 64'b01);
        chk("midrst_no_resp", 64'(mon_resp), 64'd0);
        chk("midrst_one_req", 64'(mon_req), 64'd1);
        run_walk(vecs[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sv39_ptw.md
Name: sv39_ptw

Overview:
Sv39 hardware page-table walker serving DTLB misses.
- Accepts a miss (vaddr, access type, satp snapshot) from the DTLB FSMs.
- Issues up to three 64-bit PTE reads on the TLB memory burst interface (start-burst / ack / data).
- Returns either the leaf PTE plus its level, which the DTLB writes into its LRU way, or a page-fault cause.
- Sits directly downstream of the DTLB, between it and the AXI read path.

Parameters:
ECAUSE_W, 6, width of resp_ecause (matches `ECAUSE_LEN)
PA_W, 56, physical address width; upper mem_req_addr bits are driven 0

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
req_valid  in  1  miss request
req_ready  out  1  walker can accept
req_vaddr  in  64  faulting virtual address
req_access_type  in  3  bit0 load, bit1 store, bit2 execute (one-hot)
csr_satp  in  64  satp, sampled on accept
flush  in  1  abort walk (mmu_flush_req)
mem_req_valid  out  1  one-cycle start-burst pulse
mem_req_addr  out  64  PTE physical address
mem_resp_valid  in  1  mem_ack
mem_resp_data  in  64  PTE data, valid with mem_resp_valid
resp_valid  out  1  one-cycle result pulse
resp_pte  out  64  leaf PTE
resp_level  out  2  2 = 1 GiB, 1 = 2 MiB, 0 = 4 KiB
resp_exception  out  1  page fault
resp_ecause  out  ECAUSE_W  12 instruction / 13 load / 15 store page fault
busy  out  1  state != IDLE

Behaviour:
- Reset (rst == 0 at clk edge):
  - State goes to IDLE.
  - All outputs are 0, except req_ready = 1 after reset release.
  - Reset mid-walk discards the walk; a later mem_resp_valid is ignored.
- States: IDLE, REQ, WAIT, CHECK, DONE, DRAIN.
- IDLE:
  - req_ready = !flush.
  - On req_valid & req_ready: latch vaddr, access type and satp.PPN.
  - Set base = satp.PPN << 12 and level = 2.
  - If vaddr[63:39] != {25{vaddr[38]}}: set fault and go to DONE (resp at accept + 1, no memory access).
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid = 1 for exactly one cycle.
  - mem_req_addr = base + (vpn[level] << 3), held stable until ack.
  - Go to WAIT.
- WAIT:
  - On mem_resp_valid: latch mem_resp_data and go to CHECK.
  - If flush was seen in REQ or WAIT: go to DRAIN instead.
  - An ack arriving in the same cycle as flush is consumed; go to IDLE with no resp.
- DRAIN: wait for the outstanding ack, drop its data, go to IDLE; no resp_valid.
- CHECK (one cycle, decode via sv39_pte_check):
  - V = 0, or (R = 0 & W = 1), or PTE[63:54] != 0: fault.
  - Leaf (R | X):
    - Fault if level > 0 and PPN low bits are nonzero (level 1: PPN[8:0]; level 2: PPN[17:0]).
    - Fault if the permission check fails: load needs R; store needs W; execute needs X.
    - Fault if A = 0, or if store & D = 0 (no hardware A/D update).
    - Otherwise success.
  - Pointer: fault if level == 0; else set base = PTE.PPN << 12, decrement level, go to REQ.
  - Success or fault goes to DONE.
  - Flush during CHECK goes to IDLE with no resp.
- DONE:
  - resp_valid = 1 for one cycle.
  - resp_pte / resp_level are valid on success; resp_exception / resp_ecause on fault.
  - resp_pte = 0 on fault.
  - Go to IDLE.
- Per-level latency: REQ (1) + ack wait + CHECK (1). A 4 KiB walk with 1-cycle ack returns resp_valid at accept + 10.
- mem_resp_valid outside WAIT / DRAIN is ignored.
- Only one walk is outstanding at a time; port arbitration stays in the DTLB.

Decomposition:
- Shared package constants:
  - PTE bit indices V/R/W/X/U/G/A/D.
  - PPN range [53:10] and reserved range [63:54].
  - SATP_MODE_SV39 = 8.
  - Page-fault ecause codes 12/13/15.
  - Access-type bit positions.
  - The PTW state enum.
- One combinational sub-module, sv39_pte_check: inputs PTE, level, access type; outputs is_leaf, fault.

Test Plan:
- 4 KiB walk:
  - Stimulus: satp PPN 0x80000, vaddr 0x4020_1ABC, load.
  - Required reads: 0x8000_0008, then 0x8000_1008, then 0x8000_2008.
  - Returned PTEs: 0x2000_0401 (pointer) at 0x8000_0008, 0x2000_0801 (pointer) at 0x8000_1008, 0x48D_14CF (leaf) at 0x8000_2008.
  - Response: resp_level 0, resp_pte 0x48D_14CF, exception 0, three mem_req pulses.
- 1 GiB leaf:
  - 0x1000_00CF at L2 → resp_level 2 after one read.
  - 0x1000_04CF (PPN 0x40001) → exception, ecause 13.
- Invalid PTE: store; L2 pointer, L1 PTE 0x0 → exception ecause 15 after exactly two reads.
- Store with D = 0: leaf 0x48D_144F, store → ecause 15; the same PTE on a load succeeds.
- Non-canonical vaddr 0x0000_0040_0000_0000 → resp_valid one cycle after accept, ecause 13, mem_req_valid never asserted.
- Flush and reset:
  - Flush in WAIT → no resp_valid; delayed ack dropped; req_ready returns the cycle after the ack.
  - rst low mid-walk → IDLE, outputs 0, later ack ignored.
